// File: rtl/spart_pkg.sv
// Shared definitions for the SPART echo driver: bus addresses, FSM states
// and the 50 MHz baud-divisor table.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF    = 2'b00;
  localparam logic [1:0] ADDR_STAT   = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  typedef enum logic [1:0] {
    INIT_LO = 2'b00,
    INIT_HI = 2'b01,
    RUN     = 2'b10,
    GAP     = 2'b11
  } drv_state_t;

  function automatic logic [15:0] divisor(input logic [1:0] cfg);
    case (cfg)
      2'b00:   return 16'h28B0;
      2'b01:   return 16'h1458;
      2'b10:   return 16'h0A2C;
      default: return 16'h0516;
    endcase
  endfunction

endpackage

// File: rtl/spart_driver_if.sv
// Control/status bundle between the echo driver and the SPART side.
// The tri-state data bus stays a plain inout on the driver.
interface spart_driver_if;
  logic [1:0] br_cfg;
  logic       rda;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [2:0] fifo_cnt;
  logic       init_done;

  modport master (input br_cfg, rda, tbr,
                  output iocs, iorw, ioaddr, fifo_cnt, init_done);
  modport slave  (output br_cfg, rda, tbr,
                  input iocs, iorw, ioaddr, fifo_cnt, init_done);
endinterface

// File: rtl/spart_drv_fifo.sv
// 4-entry echo buffer with wrapping 2-bit pointers and a 0..4 occupancy count.
module spart_drv_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic [2:0]        o_cnt
);

  logic [DATA_W-1:0] r_mem [4];
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [2:0]        r_cnt;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign w_push_ok = i_push && (r_cnt != 3'd4);
  assign w_pop_ok  = i_pop && (r_cnt != 3'd0);

  // The driver never pushes and pops in the same cycle, so push takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_cnt    <= 3'd0;
    end else if (w_push_ok) begin
      r_wr_ptr <= r_wr_ptr + 2'd1;
      r_cnt    <= r_cnt + 3'd1;
    end else if (w_pop_ok) begin
      r_rd_ptr <= r_rd_ptr + 2'd1;
      r_cnt    <= r_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/spart_driver.sv
// Processor-side SPART echo agent: programs the baud divisor, then reads
// received bytes into a 4-deep buffer and writes them back. Build option:
// SPART_DRV_UPCASE_EN folds lowercase ASCII to uppercase on capture.
module spart_driver
  import spart_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  spart_driver_if.master bus,
  inout  wire  [7:0]     databus
);

  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_sync_vld;
  logic [1:0] r_cfg_prog;
  drv_state_t r_state;
  logic       r_iocs;
  logic       r_iorw;
  logic [1:0] r_ioaddr;
  logic [7:0] r_wdata;
  logic       r_init_done;

  logic [2:0]  w_cnt;
  logic [7:0]  w_head;
  logic [15:0] w_div;
  logic        w_cfg_chg;
  logic        w_init_ok;
  logic        w_idle;
  logic        w_can_rd;
  logic        w_can_wr;
  logic        w_ld_lo;
  logic        w_ld_hi;
  logic        w_pop;
  logic        w_push;

  function automatic logic [7:0] rx_xform(input logic [7:0] b);
`ifdef SPART_DRV_UPCASE_EN
    return (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
`else
    return b;
`endif
  endfunction

  // High byte must come from the value latched with the low byte.
  assign w_div     = divisor((r_state == INIT_LO && r_iocs) ? r_cfg_prog : r_sync2);
  assign w_cfg_chg = (r_sync2 != r_cfg_prog);
  assign w_init_ok = r_init_done && !w_cfg_chg;
  assign w_idle    = (r_state == GAP) || (r_state == RUN && !r_iocs);
  assign w_can_rd  = bus.rda && (w_cnt != 3'd4);
  assign w_can_wr  = !w_can_rd && bus.tbr && (w_cnt != 3'd0);
  assign w_ld_lo   = (r_state == INIT_LO && !r_iocs && r_sync_vld[1]) ||
                     (w_idle && !w_init_ok);
  assign w_ld_hi   = (r_state == INIT_LO) && r_iocs;
  assign w_pop     = w_idle && w_init_ok && w_can_wr;
  assign w_push    = (r_state == RUN) && r_iocs && r_iorw;

  spart_drv_fifo #(.DATA_W(8)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (rx_xform(databus)),
    .o_rdata (w_head),
    .o_cnt   (w_cnt)
  );

  // Bus outputs are registered on the edge that enters the cycle they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 2'b00;
      r_sync2     <= 2'b00;
      r_sync_vld  <= 2'b00;
      r_cfg_prog  <= 2'b00;
      r_state     <= INIT_LO;
      r_iocs      <= 1'b0;
      r_iorw      <= 1'b1;
      r_ioaddr    <= ADDR_BUF;
      r_init_done <= 1'b0;
    end else begin
      r_sync1    <= bus.br_cfg;
      r_sync2    <= r_sync1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      r_iocs     <= 1'b0;
      r_iorw     <= 1'b1;
      r_ioaddr   <= ADDR_BUF;
      if (w_cfg_chg) r_init_done <= 1'b0;
      case (r_state)
        INIT_LO: begin
          if (w_ld_hi) begin
            r_state  <= INIT_HI;
            r_iocs   <= 1'b1;
            r_iorw   <= 1'b0;
            r_ioaddr <= ADDR_DIV_HI;
          end else if (w_ld_lo) begin
            r_iocs     <= 1'b1;
            r_iorw     <= 1'b0;
            r_ioaddr   <= ADDR_DIV_LO;
            r_cfg_prog <= r_sync2;
          end
        end
        INIT_HI: begin
          r_state <= GAP;
          if (!w_cfg_chg) r_init_done <= 1'b1;
        end
        GAP, RUN: begin
          if (r_state == RUN && r_iocs) begin
            r_state <= GAP;
          end else if (w_ld_lo) begin
            r_state    <= INIT_LO;
            r_iocs     <= 1'b1;
            r_iorw     <= 1'b0;
            r_ioaddr   <= ADDR_DIV_LO;
            r_cfg_prog <= r_sync2;
          end else begin
            r_state <= RUN;
            if (w_can_rd) begin
              r_iocs <= 1'b1;
            end else if (w_can_wr) begin
              r_iocs <= 1'b1;
              r_iorw <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_ld_hi)      r_wdata <= w_div[15:8];
    else if (w_ld_lo) r_wdata <= w_div[7:0];
    else if (w_pop)   r_wdata <= w_head;
  end

  assign databus       = (r_iocs && !r_iorw) ? r_wdata : 8'hzz;
  assign bus.iocs      = r_iocs;
  assign bus.iorw      = r_iorw;
  assign bus.ioaddr    = r_ioaddr;
  assign bus.fifo_cnt  = w_cnt;
  assign bus.init_done = r_init_done;

endmodule
